// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, memory-arbiter FSM states and
// constants used by the memory arbiter and its timeout helper.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    D_ACC,
    I_ACC,
    ABORT
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  localparam logic [31:0] ERR_WORD_DEFAULT = 32'hBAD1BAD1;
  localparam int unsigned TIMEOUT_W        = 8;

  // Saturating increment for the optional event counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/arb_timeout.sv
// Access-wait watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches the limit.
module arb_timeout
  import cpu_types_pkg::*;
(
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] count_q, count_d;
  logic [TIMEOUT_W-1:0] count_inc;

  assign count_inc = count_q + TIMEOUT_W'(1);

  always_comb begin
    count_d = count_q;
    if (clear)       count_d = '0;
    else if (enable) count_d = count_inc;
  end

  // Fires on the cycle whose increment would make the count equal the limit.
  assign expired = enable && !clear && (count_inc == limit);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging icache and dcache requests onto one RAM port,
// with error/timeout abort. Define MEM_ARBITER_PERF_EN for transfer counters.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter logic [31:0] ERR_WORD     = ERR_WORD_DEFAULT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        bus_error
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [31:0] icount,
  output logic [31:0] dcount,
  output logic [31:0] stall_count
`endif
);

  if (WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_arbiter: WAIT_TIMEOUT must be in 1..255");
  end

  arb_state_t state_q, state_d;
  grant_t     last_grant_q, last_grant_d;
  logic       gnt_is_d_q, gnt_is_d_d;
  logic       bus_error_q, bus_error_d;
  ramstate_t  ram;
  logic       d_req, in_access, tmo_enable, tmo_expired;

  assign ram        = ramstate_t'(ramstate);
  assign d_req      = dREN | dWEN;
  assign in_access  = (state_q == D_ACC) || (state_q == I_ACC);
  assign tmo_enable = in_access && (ram != ACCESS) && (ram != ERROR);
  assign bus_error  = bus_error_q;

  arb_timeout u_timeout (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (!in_access),
    .enable  (tmo_enable),
    .limit   (TIMEOUT_W'(WAIT_TIMEOUT)),
    .expired (tmo_expired)
  );

  // NOTE: every output and next-state variable gets a default first so no path
  // through the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_is_d_d   = gnt_is_d_q;
    bus_error_d  = bus_error_q;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iload        = '0;
    dload        = '0;
    iwait        = 1'b1;
    dwait        = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (d_req && (!iREN || last_grant_q == GNT_I)) state_d = D_ACC;
        else if (iREN)                                 state_d = I_ACC;
      end
      D_ACC: begin
        gnt_is_d_d = 1'b1;
        ramaddr    = daddr;
        ramWEN     = dWEN;
        ramREN     = dREN & ~dWEN;
        ramstore   = dstore;
        if (!d_req) begin
          state_d = IDLE;
        end else if (ram == ERROR || (ram != ACCESS && tmo_expired)) begin
          state_d     = ABORT;
          bus_error_d = 1'b1;
        end else if (ram == ACCESS) begin
          dwait        = 1'b0;
          dload        = dWEN ? 32'd0 : ramload;
          state_d      = IDLE;
          last_grant_d = GNT_D;
        end
      end
      I_ACC: begin
        gnt_is_d_d = 1'b0;
        ramaddr    = iaddr;
        ramREN     = iREN;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ram == ERROR || (ram != ACCESS && tmo_expired)) begin
          state_d     = ABORT;
          bus_error_d = 1'b1;
        end else if (ram == ACCESS) begin
          iwait        = 1'b0;
          iload        = ramload;
          state_d      = IDLE;
          last_grant_d = GNT_I;
        end
      end
      ABORT: begin
        state_d = IDLE;
        if (gnt_is_d_q) begin
          dwait = 1'b0;
          dload = ERR_WORD;
        end else begin
          iwait = 1'b0;
          iload = ERR_WORD;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
      gnt_is_d_q   <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_is_d_q   <= gnt_is_d_d;
      bus_error_q  <= bus_error_d;
    end
  end

`ifdef MEM_ARBITER_PERF_EN
  logic        i_done, d_done, stalled;
  logic [31:0] icount_q, icount_d, dcount_q, dcount_d, stall_q, stall_d;

  assign i_done  = (state_q == I_ACC) && iREN  && (ram == ACCESS);
  assign d_done  = (state_q == D_ACC) && d_req && (ram == ACCESS);
  assign stalled = ((state_q == D_ACC) && iREN) || ((state_q == I_ACC) && d_req);

  always_comb begin
    icount_d = i_done  ? sat_inc(icount_q) : icount_q;
    dcount_d = d_done  ? sat_inc(dcount_q) : dcount_q;
    stall_d  = stalled ? sat_inc(stall_q)  : stall_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount_q <= '0;
      dcount_q <= '0;
      stall_q  <= '0;
    end else begin
      icount_q <= icount_d;
      dcount_q <= dcount_d;
      stall_q  <= stall_d;
    end
  end

  assign icount      = icount_q;
  assign dcount      = dcount_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single fetch, contention round-robin,
// store, timeout abort, RAM error abort, withdrawal and mid-access reset.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, bus_error;

  int vectors     = 0;
  int miscompares = 0;

  mem_arbiter #(.WAIT_TIMEOUT(4)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iload     (iload),
    .iwait     (iwait),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dload     (dload),
    .dwait     (dwait),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ramstate  (ramstate),
    .bus_error (bus_error)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then changed and
  // outputs sampled a further 1 ns later, well clear of either edge.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    #3;
    check("rst_iwait", iwait, 1); check("rst_dwait", dwait, 1);
    check("rst_ramREN", ramREN, 0); check("rst_ramWEN", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0); check("rst_ramstore", ramstore, 0);
    check("rst_iload", iload, 0); check("rst_dload", dload, 0);
    check("rst_bus_error", bus_error, 0);
    #8 nRST = 1'b1;

    // 1: single instruction fetch, two BUSY cycles then ACCESS
    tick(); iREN = 1; iaddr = 32'h40; ramstate = BUSY; #1;
    check("t1_idle_ramREN", ramREN, 0); check("t1_idle_iwait", iwait, 1);
    tick(); #1;
    check("t1_ramREN", ramREN, 1); check("t1_ramaddr", ramaddr, 32'h40);
    check("t1_busy1_iwait", iwait, 1);
    tick(); #1;
    check("t1_busy2_iwait", iwait, 1);
    tick(); ramstate = ACCESS; ramload = 32'h8C010004; #1;
    check("t1_done_iwait", iwait, 0); check("t1_iload", iload, 32'h8C010004);
    check("t1_dwait", dwait, 1);
    tick(); iREN = 0; ramstate = FREE; #1;
    check("t1_after_iwait", iwait, 1); check("t1_after_ramREN", ramREN, 0);

    // 2a: contention after reset/I completion -> D first, bubble, then I
    dREN = 1; iREN = 1; daddr = 32'h100; iaddr = 32'h200; #1;
    tick(); ramstate = BUSY; #1;
    check("t2_d_ramaddr", ramaddr, 32'h100); check("t2_d_ramREN", ramREN, 1);
    check("t2_d_busy_dwait", dwait, 1);
    tick(); ramstate = ACCESS; ramload = 32'h11111111; #1;
    check("t2_d_dwait", dwait, 0); check("t2_d_dload", dload, 32'h11111111);
    check("t2_d_iwait", iwait, 1);
    tick(); dREN = 0; ramstate = FREE; #1;
    check("t2_bubble_ramREN", ramREN, 0); check("t2_bubble_iwait", iwait, 1);
    tick(); ramstate = BUSY; #1;
    check("t2_i_ramaddr", ramaddr, 32'h200);
    tick(); ramstate = ACCESS; ramload = 32'h22222222; #1;
    check("t2_i_iwait", iwait, 0); check("t2_i_iload", iload, 32'h22222222);
    tick(); iREN = 0; ramstate = FREE; #1;

    // 3: store with both enables high -> write wins, dload forced to 0
    dREN = 1; dWEN = 1; daddr = 32'h3100; dstore = 32'h5; ramload = 32'hDEADBEEF; #1;
    check("t3_idle_ramWEN", ramWEN, 0);
    tick(); ramstate = BUSY; #1;
    check("t3_ramWEN", ramWEN, 1); check("t3_ramREN", ramREN, 0);
    check("t3_ramstore", ramstore, 32'h5); check("t3_ramaddr", ramaddr, 32'h3100);
    check("t3_busy_dwait", dwait, 1);
    tick(); ramstate = ACCESS; #1;
    check("t3_dwait", dwait, 0); check("t3_dload", dload, 0);
    tick(); dREN = 0; dWEN = 0; ramstate = FREE; #1;

    // 2b: last grant now D, so the next contention serves I first
    dREN = 1; iREN = 1; daddr = 32'h104; iaddr = 32'h204; #1;
    tick(); ramstate = ACCESS; ramload = 32'h33333333; #1;
    check("t2b_i_ramaddr", ramaddr, 32'h204); check("t2b_i_iwait", iwait, 0);
    check("t2b_i_iload", iload, 32'h33333333); check("t2b_dwait", dwait, 1);
    tick(); iREN = 0; ramstate = FREE; #1;
    check("t2b_bubble_dwait", dwait, 1);
    tick(); ramstate = ACCESS; ramload = 32'h44444444; #1;
    check("t2b_d_ramaddr", ramaddr, 32'h104); check("t2b_d_dwait", dwait, 0);
    check("t2b_d_dload", dload, 32'h44444444);
    tick(); dREN = 0; ramstate = FREE; #1;
    check("pre_t4_bus_error", bus_error, 0);

    // 4: RAM stuck BUSY -> four access cycles, then ABORT with poison word
    iREN = 1; iaddr = 32'h80; ramstate = BUSY; #1;
    for (int c = 1; c <= 4; c++) begin
      tick(); #1;
      check($sformatf("t4_acc%0d_iwait", c), iwait, 1);
      check($sformatf("t4_acc%0d_ramREN", c), ramREN, 1);
    end
    tick(); #1;
    check("t4_abort_iwait", iwait, 0); check("t4_abort_iload", iload, ERR_WORD_DEFAULT);
    check("t4_abort_ramREN", ramREN, 0); check("t4_abort_dwait", dwait, 1);
    check("t4_abort_dload", dload, 0);
    tick(); iREN = 0; ramstate = FREE; #1;
    check("t4_bus_error", bus_error, 1); check("t4_idle_iwait", iwait, 1);

    // 5: RAM ERROR on the second D access cycle -> ABORT, then normal access
    dREN = 1; daddr = 32'h200; ramstate = BUSY; #1;
    tick(); #1;
    check("t5_busy_dwait", dwait, 1);
    tick(); ramstate = ERROR; ramload = 32'h77777777; #1;
    check("t5_err_dwait", dwait, 1);
    tick(); ramstate = FREE; #1;
    check("t5_abort_dwait", dwait, 0); check("t5_abort_dload", dload, ERR_WORD_DEFAULT);
    check("t5_abort_ramREN", ramREN, 0); check("t5_abort_iwait", iwait, 1);
    tick(); dREN = 0; #1;
    dREN = 1; daddr = 32'h208; #1;
    tick(); ramstate = ACCESS; ramload = 32'h55555555; #1;
    check("t5_ok_dwait", dwait, 0); check("t5_ok_dload", dload, 32'h55555555);
    check("t5_bus_error_sticky", bus_error, 1);
    tick(); dREN = 0; ramstate = FREE; #1;

    // withdrawal mid-access: enables drop in the same cycle, no fault raised
    dREN = 1; daddr = 32'h20C; ramstate = BUSY; #1;
    tick(); #1;
    check("wd_ramREN_on", ramREN, 1);
    dREN = 0; #1;
    check("wd_ramREN_off", ramREN, 0); check("wd_dwait", dwait, 1);
    tick(); #1;

    // 6: reset during D access (last grant D) -> outputs safe, D wins after
    dREN = 1; daddr = 32'h300; ramstate = BUSY; #1;
    tick(); #1;
    check("t6_ramREN_pre", ramREN, 1);
    nRST = 0; #1;
    check("t6_ramREN", ramREN, 0); check("t6_ramaddr", ramaddr, 0);
    check("t6_dwait", dwait, 1); check("t6_iwait", iwait, 1);
    check("t6_bus_error", bus_error, 0);
    nRST = 1; iREN = 1; iaddr = 32'h400; #1;
    tick(); #1;
    check("t6_grant_d_ramaddr", ramaddr, 32'h300); check("t6_grant_iwait", iwait, 1);
    ramstate = ACCESS; ramload = 32'h66666666; #1;
    check("t6_d_dwait", dwait, 0); check("t6_d_dload", dload, 32'h66666666);
    tick(); dREN = 0; iREN = 0; ramstate = FREE; #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
